regfile_mp_sb: RTL and testbench

- Parametrised multi-port register file with write-to-read bypass and a per-register pending-write scoreboard.
- Successor to the single-write, dual-read, negedge-write register file. It serves the pipelined and multi-issue datapath, where multi-cycle units write back late.
- Decode issues a destination to mark it pending. Writeback ports clear the pending state. Read ports return data plus a hazard flag that the hazard unit consumes directly.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_sb_bits.sv | 25 ++
 rtl/regfile_mp_sb.sv | 85 ++++++++
 tb/tb_regfile_mp_sb.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants, select type and write-port arbitration for regfile_mp_sb.
package regfile_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NREGS  = 32;
  localparam int DEF_AW     = $clog2(DEF_NREGS);
  localparam int MAX_WP     = 8;
  localparam int MAX_AW     = 16;
  localparam int WPI_W      = $clog2(MAX_WP);
  typedef logic [DEF_AW-1:0] regsel_t;
  typedef struct packed {
    logic             hit;
    logic [WPI_W-1:0] idx;
  } wpick_t;
  // Highest-index enabled port targeting a nonzero addr wins; register 0 never hits.
  function automatic wpick_t pick_write(input logic [MAX_AW-1:0] addr,
                                        input logic [MAX_WP-1:0] wen,
                                        input logic [MAX_WP-1:0][MAX_AW-1:0] wsel);
    wpick_t p;
    p = '0;
    for (int j = 0; j < MAX_WP; j++)
      if (wen[j] && addr != '0 && wsel[j] == addr) begin
        p.hit = 1'b1;
        p.idx = WPI_W'(j);
      end
    return p;
  endfunction
endpackage

// File: rtl/regfile_sb_bits.sv
// regfile_sb_bits: per-register pending bits; issue beats flush beats writeback clear.
module regfile_sb_bits #(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_iss_en,
  input  logic [AW-1:0]    i_iss_sel,
  input  logic             i_flush,
  input  logic [NREGS-1:0] i_wr_hit,
  output logic [NREGS-1:0] o_pend
);
  logic [NREGS-1:0] r_pend;
  logic [NREGS-1:0] w_pend_nx;
  always_comb begin
    w_pend_nx = '0;
    for (int r = 1; r < NREGS; r++)
      w_pend_nx[r] = (i_iss_en && i_iss_sel == AW'(r)) ? 1'b1 :
                     (i_flush || i_wr_hit[r])          ? 1'b0 : r_pend[r];
  end
  always_ff @(posedge i_clk)
    r_pend <= !i_rst_n ? '0 : w_pend_nx;
  assign o_pend = r_pend;
endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with same-cycle write bypass and pending-write scoreboard.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int NREGS  = DEF_NREGS,
  parameter  int NREAD  = 2,
  parameter  int NWRITE = 2,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NREAD*AW-1:0]      rsel,
  output logic [NREAD*DATA_W-1:0]  rdat,
  output logic [NREAD-1:0]         rhaz,
  input  logic [NWRITE-1:0]        wen,
  input  logic [NWRITE*AW-1:0]     wsel,
  input  logic [NWRITE*DATA_W-1:0] wdat,
  input  logic                     iss_en,
  input  logic [AW-1:0]            iss_sel,
  input  logic                     flush,
  output logic [NREGS-1:0]         pend,
  output logic                     wr_collide
);
  logic [NREGS-1:0][DATA_W-1:0]   r_regs;
  logic [NREGS-1:0][DATA_W-1:0]   w_regs_nx;
  logic [NREGS-1:0]               w_wr_hit;
  logic                           r_coll;
  logic                           w_coll;
  logic [MAX_WP-1:0]              w_wen_ext;
  logic [MAX_WP-1:0][MAX_AW-1:0]  w_wsel_ext;
  always_comb begin
    w_wen_ext  = '0;
    w_wsel_ext = '0;
    for (int j = 0; j < NWRITE; j++) begin
      w_wen_ext[j]  = wen[j];
      w_wsel_ext[j] = MAX_AW'(wsel[j*AW +: AW]);
    end
  end
  always_comb begin
    wpick_t pk;
    pk   = '0;
    rdat = '0;
    rhaz = '0;
    for (int i = 0; i < NREAD; i++) begin
      pk = pick_write(MAX_AW'(rsel[i*AW +: AW]), w_wen_ext, w_wsel_ext);
      rdat[i*DATA_W +: DATA_W] = pk.hit ? wdat[pk.idx*DATA_W +: DATA_W] : r_regs[rsel[i*AW +: AW]];
      rhaz[i] = !pk.hit && pend[rsel[i*AW +: AW]];
    end
  end
  always_comb begin
    wpick_t pk;
    pk        = '0;
    w_regs_nx = r_regs;
    w_wr_hit  = '0;
    w_coll    = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      pk = pick_write(MAX_AW'(r), w_wen_ext, w_wsel_ext);
      w_wr_hit[r] = pk.hit;
      if (pk.hit) w_regs_nx[r] = wdat[pk.idx*DATA_W +: DATA_W];
    end
    for (int j = 0; j < NWRITE; j++)
      for (int k = j + 1; k < NWRITE; k++)
        w_coll |= wen[j] && wen[k] && wsel[j*AW +: AW] == wsel[k*AW +: AW] && wsel[j*AW +: AW] != '0;
  end
  always_ff @(posedge CLK)
    if (!nRST) begin
      r_regs <= '0;
      r_coll <= 1'b0;
    end else begin
      r_regs <= w_regs_nx;
      r_coll <= r_coll | w_coll;
    end
  // A single write port can never collide, so keep the flag tied off from power-up.
  assign wr_collide = (NWRITE > 1) && r_coll;
  regfile_sb_bits #(.NREGS(NREGS), .AW(AW)) u_sb (
    .i_clk    (CLK),
    .i_rst_n  (nRST),
    .i_iss_en (iss_en),
    .i_iss_sel(iss_sel),
    .i_flush  (flush),
    .i_wr_hit (w_wr_hit),
    .o_pend   (pend)
  );
endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed plus randomized checks of regfile_mp_sb against an array-based model.
module tb_regfile_mp_sb;
  logic        CLK = 1'b0;
  logic        nRST;
  logic [9:0]  rsel;
  logic [63:0] rdat;
  logic [1:0]  rhaz;
  logic [1:0]  wen;
  logic [9:0]  wsel;
  logic [63:0] wdat;
  logic        iss_en;
  logic [4:0]  iss_sel;
  logic        flush;
  logic [31:0] pend;
  logic        wr_collide;
  logic [31:0] m_regs [32];
  logic [31:0] m_pend;
  logic        m_coll;
  int          n_chk = 0;
  int          n_err = 0;
  regfile_mp_sb dut (
    .CLK(CLK), .nRST(nRST), .rsel(rsel), .rdat(rdat), .rhaz(rhaz),
    .wen(wen), .wsel(wsel), .wdat(wdat), .iss_en(iss_en), .iss_sel(iss_sel),
    .flush(flush), .pend(pend), .wr_collide(wr_collide)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic idle();
    nRST = 1'b1; wen = '0; wsel = '0; wdat = '0; iss_en = 1'b0; iss_sel = '0; flush = 1'b0;
  endtask
  // Check outputs against model for the current inputs, then advance model across posedge.
  task automatic step();
    logic [31:0] ed;
    logic        eh;
    logic [31:0] wr;
    int          a;
    int          s;
    #2;
    for (int i = 0; i < 2; i++) begin
      a  = int'(rsel[i*5 +: 5]);
      ed = m_regs[a];
      eh = m_pend[a];
      for (int j = 0; j < 2; j++)
        if (wen[j] && int'(wsel[j*5 +: 5]) == a && a != 0) begin
          ed = wdat[j*32 +: 32];
          eh = 1'b0;
        end
      if (a == 0) begin ed = '0; eh = 1'b0; end
      chk($sformatf("rdat%0d_r%0d", i, a), 64'(rdat[i*32 +: 32]), 64'(ed));
      chk($sformatf("rhaz%0d_r%0d", i, a), 64'(rhaz[i]), 64'(eh));
    end
    chk("pend", 64'(pend), 64'(m_pend));
    chk("wr_collide", 64'(wr_collide), 64'(m_coll));
    @(posedge CLK);
    if (!nRST) begin
      for (int r = 0; r < 32; r++) m_regs[r] = '0;
      m_pend = '0;
      m_coll = 1'b0;
    end else begin
      wr = '0;
      for (int j = 0; j < 2; j++) begin
        s = int'(wsel[j*5 +: 5]);
        if (wen[j] && s != 0) begin
          if (wr[s]) m_coll = 1'b1;
          wr[s] = 1'b1;
          m_regs[s] = wdat[j*32 +: 32];
        end
      end
      m_pend &= ~wr;
      if (flush) m_pend = '0;
      if (iss_en && iss_sel != 0) m_pend[iss_sel] = 1'b1;
    end
    @(negedge CLK);
  endtask
  initial begin
    idle();
    rsel = '0;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    for (int r = 0; r < 32; r++) m_regs[r] = '0;
    m_pend = '0;
    m_coll = 1'b0;
    nRST = 1'b1;
    for (int r = 0; r < 32; r += 2) begin
      rsel = {5'(r + 1), 5'(r)};
      step();
    end
    rsel = {5'd0, 5'd5}; wen = 2'b01; wsel = {5'd0, 5'd5}; wdat = {32'h0, 32'hDEADBEEF};
    #1 chk("bypass_r5", 64'(rdat[31:0]), 64'h0000_0000_DEAD_BEEF);
    step();
    idle();
    #1 chk("stored_r5", 64'(rdat[31:0]), 64'h0000_0000_DEAD_BEEF);
    step();
    rsel = {5'd0, 5'd0}; wen = 2'b11; wsel = {5'd0, 5'd0}; wdat = {32'h1234, 32'h1234};
    step();
    idle();
    #1 chk("r0_zero", 64'(rdat[31:0]), 64'h0);
    chk("no_coll_r0", 64'(wr_collide), 64'h0);
    step();
    rsel = {5'd7, 5'd7}; wen = 2'b11; wsel = {5'd7, 5'd7}; wdat = {32'h22, 32'h11};
    #1 chk("coll_bypass_r7", 64'(rdat[31:0]), 64'h22);
    step();
    idle();
    #1 chk("coll_store_r7", 64'(rdat[63:32]), 64'h22);
    chk("coll_set", 64'(wr_collide), 64'h1);
    repeat (3) step();
    chk("coll_sticky", 64'(wr_collide), 64'h1);
    iss_en = 1'b1; iss_sel = 5'd9; rsel = {5'd0, 5'd9};
    step();
    idle();
    #1 chk("iss_pend9", 64'(pend[9]), 64'h1);
    chk("iss_rhaz9", 64'(rhaz[0]), 64'h1);
    step();
    wen = 2'b10; wsel = {5'd9, 5'd0}; wdat = {32'h55, 32'h0};
    #1 chk("wb_rhaz9", 64'(rhaz[0]), 64'h0);
    chk("wb_rdat9", 64'(rdat[31:0]), 64'h55);
    step();
    idle();
    #1 chk("wb_clear9", 64'(pend[9]), 64'h0);
    step();
    iss_en = 1'b1; iss_sel = 5'd12;
    step();
    iss_en = 1'b1; iss_sel = 5'd3; flush = 1'b1; wen = 2'b01; wsel = {5'd0, 5'd3}; wdat = {32'h0, 32'hCAFE0003};
    step();
    idle();
    rsel = {5'd0, 5'd3};
    #1 chk("iss_wins_pend", 64'(pend), 64'h8);
    chk("iss_wins_data", 64'(rdat[31:0]), 64'hCAFE0003);
    step();
    nRST = 1'b0;
    step();
    idle();
    rsel = {5'd7, 5'd3};
    #1 chk("rst_pend", 64'(pend), 64'h0);
    chk("rst_coll", 64'(wr_collide), 64'h0);
    chk("rst_r3", 64'(rdat[31:0]), 64'h0);
    step();
    for (int n = 0; n < 400; n++) begin
      nRST    = ($urandom_range(0, 49) != 0);
      rsel    = 10'($urandom);
      wen     = 2'($urandom);
      wsel    = ($urandom_range(0, 1) != 0) ? 10'($urandom) : {2'b0, 3'($urandom), 2'b0, 3'($urandom)};
      wdat    = {$urandom, $urandom};
      iss_en  = ($urandom_range(0, 2) == 0);
      iss_sel = 5'($urandom);
      flush   = ($urandom_range(0, 15) == 0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
